// File: rtl/hamming_dec_s.sv
// Serial Hamming(10,6) decoder: bits arrive position 1 first, the syndrome builds up as
// bits are captured, and the corrected 6-bit word is presented one cycle after position 10.
module hamming_dec_s (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       sof,
    output logic [5:0] d_out,
    output logic       out_valid,
    output logic       err_corr,
    output logic       err_uncorr,
    output logic       busy
);

    logic [3:0] cnt;
    logic [3:0] syn;
    logic [9:0] word;

    logic [3:0] pos;
    logic [3:0] syn_next;
    logic [9:0] word_next;
    logic [9:0] flip;
    logic [9:0] fixed;

    // The incoming bit's position; sof or an idle counter restarts the frame at 1.
    always_comb begin
        pos = (sof || (cnt == 4'd0)) ? 4'd1 : cnt + 4'd1;

        word_next = (pos == 4'd1) ? 10'd0 : word;
        word_next[pos - 4'd1] = bit_in;

        syn_next = ((pos == 4'd1) ? 4'd0 : syn) ^ (bit_in ? pos : 4'd0);

        for (int i = 0; i < 10; i++) begin
            flip[i] = (syn_next == 4'(i + 1));
        end
        fixed = word_next ^ flip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            syn        <= 4'd0;
            word       <= 10'd0;
            d_out      <= 6'd0;
            out_valid  <= 1'b0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (bit_valid) begin
                cnt  <= (pos == 4'd10) ? 4'd0 : pos;
                word <= word_next;
                syn  <= syn_next;
                // Final bit: publish the corrected data and error flags together.
                if (pos == 4'd10) begin
                    out_valid  <= 1'b1;
                    d_out      <= {fixed[9], fixed[8], fixed[6], fixed[5], fixed[4], fixed[2]};
                    err_corr   <= (syn_next >= 4'd1) && (syn_next <= 4'd10);
                    err_uncorr <= (syn_next >= 4'd11);
                end
            end
        end
    end

    assign busy = (cnt >= 4'd1) && (cnt <= 4'd9);

endmodule

// File: tb/tb_hamming_dec_s.sv
// Self-checking bench for hamming_dec_s: directed frames plus randomized frames
// compared against a parity-check-equation model of Hamming(10,6).
module tb_hamming_dec_s;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic       sof;
    logic [5:0] d_out;
    logic       out_valid;
    logic       err_corr;
    logic       err_uncorr;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int cnt_m  = 0;

    hamming_dec_s dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .sof        (sof),
        .d_out      (d_out),
        .out_valid  (out_valid),
        .err_corr   (err_corr),
        .err_uncorr (err_uncorr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid === 1'b1) pulses++;
    end

    function automatic logic [10:1] encode(input logic [5:0] d);
        logic [10:1] c;
        int dp[6] = '{3, 5, 6, 7, 9, 10};
        c = '0;
        for (int i = 0; i < 6; i++) c[dp[i]] = d[i];
        for (int k = 0; k < 4; k++) begin
            int  p   = 1 << k;
            logic par = 1'b0;
            for (int j = 1; j <= 10; j++)
                if (j != p && (j & p) != 0) par ^= c[j];
            c[p] = par;
        end
        return c;
    endfunction

    function automatic void model(input logic [10:1] cw, output logic [5:0] d,
                                  output logic ec, output logic eu);
        logic [10:1] c;
        int dp[6] = '{3, 5, 6, 7, 9, 10};
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            logic chk = 1'b0;
            for (int j = 1; j <= 10; j++)
                if ((j & (1 << k)) != 0) chk ^= cw[j];
            if (chk) s += (1 << k);
        end
        c  = cw;
        ec = (s >= 1 && s <= 10);
        eu = (s >= 11);
        if (ec) c[s] = ~c[s];
        for (int i = 0; i < 6; i++) d[i] = c[dp[i]];
    endfunction

    // One negedge per call (unless skip_edge); busy is checked against the position model first.
    task automatic drive_bit(input logic b, input logic s, input logic v, input logic skip_edge);
        if (!skip_edge) @(negedge clk);
        checks++;
        if (busy !== ((cnt_m >= 1 && cnt_m <= 9) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("[TB] FAIL busy: got %b expected %b (model pos %0d) at %0t",
                     busy, (cnt_m >= 1 && cnt_m <= 9), cnt_m, $time);
        end
        bit_in = b; sof = s; bit_valid = v;
        if (v) begin
            if (s || cnt_m == 0) cnt_m = 1;
            else cnt_m++;
            if (cnt_m == 10) cnt_m = 0;
        end
    endtask

    task automatic send_frame(input logic [10:1] cw, input logic use_sof, input int gap_pct,
                              input int first_j);
        for (int j = first_j; j <= 10; j++) begin
            for (int g = 0; g < 2; g++)
                if (int'($urandom_range(99)) < gap_pct)
                    drive_bit(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b0);
            drive_bit(cw[j], use_sof && (j == 1), 1'b1, 1'b0);
        end
    endtask

    task automatic expect_out(input string name, input logic [5:0] d, input logic ec, input logic eu);
        checks++;
        if ({out_valid, err_corr, err_uncorr, d_out} !== {1'b1, ec, eu, d}) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b corr=%b uncorr=%b d=%b expected valid=1 corr=%b uncorr=%b d=%b",
                     name, out_valid, err_corr, err_uncorr, d_out, ec, eu, d);
        end
    endtask

    task automatic expect_hold(input string name, input logic [5:0] d, input logic ec, input logic eu);
        @(negedge clk);
        checks++;
        if ({out_valid, err_corr, err_uncorr, d_out} !== {1'b0, ec, eu, d}) begin
            errors++;
            $display("[TB] FAIL %s hold: got valid=%b corr=%b uncorr=%b d=%b expected valid=0 corr=%b uncorr=%b d=%b",
                     name, out_valid, err_corr, err_uncorr, d_out, ec, eu, d);
        end
    endtask

    task automatic finish_frame(input string name, input logic [5:0] d, input logic ec, input logic eu);
        @(negedge clk);
        expect_out(name, d, ec, eu);
        bit_valid = 1'b0; sof = 1'b0;
        expect_hold(name, d, ec, eu);
    endtask

    function automatic logic [10:1] spec_frame();
        logic [10:1] c;
        int s[10] = '{0, 0, 1, 0, 0, 1, 1, 1, 0, 1};
        for (int j = 1; j <= 10; j++) c[j] = s[j-1][0];
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0;
        cnt_m = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, err_corr, err_uncorr, busy, d_out} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset: got valid=%b corr=%b uncorr=%b busy=%b d=%b expected all 0",
                     out_valid, err_corr, err_uncorr, busy, d_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [10:1] c = spec_frame();
        logic [10:1] f;
        send_frame(c, 1'b1, 0, 1);
        finish_frame("clean", 6'b101101, 1'b0, 1'b0);
        f = c; f[6] = ~f[6];
        send_frame(f, 1'b1, 0, 1);
        finish_frame("data_err", 6'b101101, 1'b1, 1'b0);
        f = c; f[8] = ~f[8];
        send_frame(f, 1'b0, 0, 1);
        finish_frame("parity_err", 6'b101101, 1'b1, 1'b0);
        f = c; f[3] = ~f[3]; f[8] = ~f[8];
        send_frame(f, 1'b1, 0, 1);
        finish_frame("uncorr", 6'b101100, 1'b0, 1'b1);
    endtask

    task automatic test_gaps_resync();
        int p0 = pulses;
        logic [10:1] c = encode(6'b010011);
        for (int j = 1; j <= 4; j++) begin
            drive_bit(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
            drive_bit(1'($urandom_range(1)), 1'b0, 1'b1, 1'b0);
        end
        send_frame(c, 1'b1, 40, 1);
        finish_frame("resync", 6'b010011, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (pulses - p0 !== 1) begin
            errors++;
            $display("[TB] FAIL resync_pulses: got %0d expected 1", pulses - p0);
        end
    endtask

    task automatic test_reset_midframe();
        int p0;
        logic [10:1] c = encode(6'b110110);
        c[5] = ~c[5];
        send_frame(c, 1'b1, 0, 1);
        finish_frame("pre_reset", 6'b110110, 1'b1, 1'b0);
        p0 = pulses;
        c = encode(6'b011001);
        for (int j = 1; j <= 5; j++) drive_bit(c[j], j == 1, 1'b1, 1'b0);
        @(negedge clk);
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, err_corr, err_uncorr, busy, d_out} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL midframe_reset: got valid=%b corr=%b uncorr=%b busy=%b d=%b expected all 0",
                     out_valid, err_corr, err_uncorr, busy, d_out);
        end
        cnt_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pulses !== p0) begin
            errors++;
            $display("[TB] FAIL midframe_pulses: got %0d expected %0d", pulses - p0, 0);
        end
        send_frame(c, 1'b0, 20, 1);
        finish_frame("post_reset", 6'b011001, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0] d, ed;
        logic ec, eu;
        logic [10:1] c;
        for (int n = 0; n < 40; n++) begin
            d = 6'($urandom);
            c = encode(d);
            for (int e = int'($urandom_range(2)); e > 0; e--) begin
                int p = int'($urandom_range(10, 1));
                c[p] = ~c[p];
            end
            model(c, ed, ec, eu);
            send_frame(c, 1'($urandom_range(1)), 25, 1);
            finish_frame("random", ed, ec, eu);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] d, ed;
        logic ec, eu;
        logic [10:1] c;
        int p0 = pulses;
        for (int n = 0; n < 6; n++) begin
            c = encode(6'($urandom));
            if (n % 2 == 1) begin
                int p = int'($urandom_range(10, 1));
                c[p] = ~c[p];
            end
            if (n == 0) begin
                send_frame(c, 1'b1, 0, 1);
            end else begin
                @(negedge clk);
                expect_out("b2b", ed, ec, eu);
                drive_bit(c[1], 1'($urandom_range(1)), 1'b1, 1'b1);
                send_frame(c, 1'b0, 0, 2);
            end
            model(c, ed, ec, eu);
        end
        finish_frame("b2b_last", ed, ec, eu);
        repeat (2) @(negedge clk);
        checks++;
        if (pulses - p0 !== 6) begin
            errors++;
            $display("[TB] FAIL b2b_pulses: got %0d expected 6", pulses - p0);
        end
        d = ed;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_gaps_resync();
        test_reset_midframe();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
